// File: rtl/minimig_ar_pkg.sv
// Shared Action Replay definitions: FSM state encoding, Amiga raw keycodes
// and the freeze timer width.
package minimig_ar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_REL = 2'd3
  } ar_state_t;

  localparam logic [6:0] KC_CTRL = 7'h63;
  localparam logic [6:0] KC_HELP = 7'h5F;

  localparam int CNT_W = 16;

endpackage

// File: rtl/freeze_pulse_timer.sv
// Down-counter with terminal-count flag, time-shared by the freeze pulse
// and the holdoff window.
module freeze_pulse_timer
  import minimig_ar_pkg::*;
(
  input  logic             clk,
  input  logic             _reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/freeze_keygen.sv
// Ctrl+trigger / OSD freeze request generator for the Action Replay cartridge.
// Optional macro FREEZE_SWALLOW_EN hides the trigger key from the CIA path.
//
// state    | meaning
// IDLE     | waiting for a request
// PULSE    | freeze held high for PULSE_CYCLES
// HOLDOFF  | freeze low, new requests dropped for HOLDOFF_CYCLES
// WAIT_REL | holdoff over, waiting for the trigger key to be released
module freeze_keygen
  import minimig_ar_pkg::*;
#(
  parameter logic [6:0] CTRL_CODE      = KC_CTRL,
  parameter logic [6:0] TRIG_CODE      = KC_HELP,
  parameter int         PULSE_CYCLES   = 16,
  parameter int         HOLDOFF_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       aron,
  input  logic       kbd_valid,
  input  logic [6:0] kbd_code,
  input  logic       kbd_up,
  input  logic       osd_freeze,
  output logic       freeze,
  output logic       busy,
  output logic       kbd_valid_o,
  output logic [6:0] kbd_code_o,
  output logic       kbd_up_o
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

  ar_state_t        state;
  logic             ctrl_held;
  logic             trig_down;
  logic             trig_down_nxt;
  logic             osd_freeze_d;
  logic             trig_press;
  logic             trig_rel;
  logic             key_req;
  logic             osd_req;
  logic             req;
  logic             accept;
  logic             swallow;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_tc;

  assign trig_press = kbd_valid && kbd_code == TRIG_CODE && !kbd_up;
  assign trig_rel   = kbd_valid && kbd_code == TRIG_CODE &&  kbd_up;
  // registered ctrl_held: Ctrl arriving in the same event cycle does not count
  assign key_req    = aron && trig_press && ctrl_held;
  assign osd_req    = aron && osd_freeze && !osd_freeze_d;
  assign req        = key_req || osd_req;
  assign accept     = (state == IDLE) && req;

  assign trig_down_nxt = (trig_down && !trig_rel) || (accept && key_req);

`ifdef FREEZE_SWALLOW_EN
  assign swallow = key_req || (trig_rel && trig_down);
`else
  assign swallow = 1'b0;
`endif

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = PULSE_LOAD;
    tmr_dec      = 1'b0;
    case (state)
      IDLE: begin
        tmr_load = accept;
      end
      PULSE: begin
        if (!aron || tmr_tc) begin
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLDOFF: begin
        tmr_dec = 1'b1;
      end
      default: ;
    endcase
  end

  freeze_pulse_timer u_timer (
    .clk      (clk),
    ._reset   (_reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!_reset) begin
      ctrl_held    <= 1'b0;
      osd_freeze_d <= 1'b0;
      trig_down    <= 1'b0;
    end else begin
      osd_freeze_d <= osd_freeze;
      trig_down    <= trig_down_nxt;
      if (kbd_valid && kbd_code == CTRL_CODE)
        ctrl_held <= !kbd_up;
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state  <= IDLE;
      freeze <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state  <= PULSE;
            freeze <= 1'b1;
            busy   <= 1'b1;
          end
        end
        PULSE: begin
          // aron dropping ends the pulse early and still enforces holdoff
          if (!aron || tmr_tc) begin
            state  <= HOLDOFF;
            freeze <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (tmr_tc) begin
            if (trig_down_nxt) begin
              state <= WAIT_REL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WAIT_REL: begin
          if (!trig_down_nxt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          freeze <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      kbd_valid_o <= 1'b0;
      kbd_code_o  <= '0;
      kbd_up_o    <= 1'b0;
    end else begin
      kbd_valid_o <= kbd_valid && !swallow;
      kbd_code_o  <= kbd_code;
      kbd_up_o    <= kbd_up;
    end
  end

endmodule

// File: tb/tb_freeze_keygen.sv
// Self-checking bench for freeze_keygen: directed table, corner sequences and
// random traffic against a timestamp-based reference model.
module tb_freeze_keygen;

  localparam int P = 16;
  localparam int H = 100;
  localparam logic [6:0] KC = 7'h63;
  localparam logic [6:0] KT = 7'h5F;
`ifdef FREEZE_SWALLOW_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       _reset = 1'b0;
  logic       aron = 1'b0;
  logic       kbd_valid = 1'b0;
  logic [6:0] kbd_code = '0;
  logic       kbd_up = 1'b0;
  logic       osd_freeze = 1'b0;
  logic       freeze, busy, kbd_valid_o, kbd_up_o;
  logic [6:0] kbd_code_o;

  freeze_keygen #(
    .CTRL_CODE(KC), .TRIG_CODE(KT), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk), ._reset(_reset), .aron(aron), .kbd_valid(kbd_valid),
    .kbd_code(kbd_code), .kbd_up(kbd_up), .osd_freeze(osd_freeze),
    .freeze(freeze), .busy(busy), .kbd_valid_o(kbd_valid_o),
    .kbd_code_o(kbd_code_o), .kbd_up_o(kbd_up_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rises = 0;
  int highs = 0;
  int fwd = 0;
  bit prev_freeze = 1'b0;

  // reference model: pulse/holdoff windows as absolute cycle stamps
  int   m_pulse_start = 0, m_freeze_end = 0, m_hold_end = 0;
  bit   m_ctrl = 0, m_trig = 0, m_osd_d = 0, m_busy = 0, m_freeze = 0;
  bit   m_vo = 0, m_uo = 0;
  logic [6:0] m_co = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit key_req, osd_req, rel_trig, press_trig, was_busy, was_pulse;
    cyc++;
    if (!_reset) begin
      m_pulse_start = 0; m_freeze_end = 0; m_hold_end = 0;
      m_ctrl = 0; m_trig = 0; m_osd_d = 0;
      m_vo = 0; m_co = '0; m_uo = 0;
    end else begin
      press_trig = kbd_valid && kbd_code == KT && !kbd_up;
      rel_trig   = kbd_valid && kbd_code == KT &&  kbd_up;
      key_req    = aron && press_trig && m_ctrl;
      osd_req    = aron && osd_freeze && !m_osd_d;
      was_busy   = m_busy;
      was_pulse  = m_freeze;
      m_vo = kbd_valid && !(SW && (key_req || (rel_trig && m_trig)));
      m_co = kbd_code;
      m_uo = kbd_up;
      if (rel_trig) m_trig = 0;
      if (!was_busy && (key_req || osd_req)) begin
        m_pulse_start = cyc;
        m_freeze_end  = cyc + P;
        m_hold_end    = cyc + P + H;
        if (key_req) m_trig = 1;
      end else if (was_pulse && !aron && cyc < m_freeze_end) begin
        m_freeze_end = cyc;
        m_hold_end   = cyc + H;
      end
      if (kbd_valid && kbd_code == KC) m_ctrl = !kbd_up;
      m_osd_d = osd_freeze;
    end
    m_freeze = (cyc >= m_pulse_start) && (cyc < m_freeze_end);
    m_busy   = (cyc < m_hold_end) || m_trig;
  endtask

  task automatic step(input bit rst, input bit a, input bit v, input logic [6:0] c,
                      input bit u, input bit o);
    _reset = rst; aron = a; kbd_valid = v; kbd_code = c; kbd_up = u; osd_freeze = o;
    @(posedge clk);
    model_step();
    #1;
    check("freeze", freeze, m_freeze);
    check("busy", busy, m_busy);
    check("kbd_valid_o", kbd_valid_o, m_vo);
    check("kbd_code_o", kbd_code_o, m_co);
    check("kbd_up_o", kbd_up_o, m_uo);
    if (freeze && !prev_freeze) rises++;
    if (freeze) highs++;
    if (kbd_valid_o) fwd++;
    prev_freeze = freeze;
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(1, a, 0, 7'h00, 0, 0);
  endtask

  task automatic key(input logic [6:0] c, input bit u);
    step(1, 1, 1, c, u, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      idle(1, 1);
    end
    check("wait_idle", busy, 0);
  endtask

  typedef struct {
    bit rst, a, v;
    logic [6:0] c;
    bit u, o;
    bit e_frz, e_busy, e_vo;
    logic [6:0] e_co;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 0, 7'h00, 0, 0, 0, 0, 0,   7'h00};
    tbl[1] = '{1, 1, 0, 7'h00, 0, 0, 0, 0, 0,   7'h00};
    tbl[2] = '{1, 1, 1, KC,    0, 0, 0, 0, 1,   KC};
    tbl[3] = '{1, 1, 0, 7'h00, 0, 0, 0, 0, 0,   7'h00};
    tbl[4] = '{1, 1, 1, KT,    0, 0, 1, 1, !SW, KT};
    tbl[5] = '{1, 1, 0, 7'h00, 0, 0, 1, 1, 0,   7'h00};
    tbl[6] = '{1, 1, 0, 7'h00, 0, 0, 1, 1, 0,   7'h00};
    tbl[7] = '{1, 1, 0, 7'h00, 0, 1, 1, 1, 0,   7'h00};

    // directed table: reset, Ctrl press, trigger press with 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].a, tbl[i].v, tbl[i].c, tbl[i].u, tbl[i].o);
      check("tbl_freeze", freeze, tbl[i].e_frz);
      check("tbl_busy", busy, tbl[i].e_busy);
      check("tbl_valid_o", kbd_valid_o, tbl[i].e_vo);
      check("tbl_code_o", kbd_code_o, tbl[i].e_co);
    end

    // trigger still held: holdoff expires into WAIT_REL
    idle(P + H + 10, 1);
    check("waitrel_busy", busy, 1);
    key(KT, 1);
    check("waitrel_exit", busy, 0);
    check("rel_swallow", kbd_valid_o, !SW);

    // typematic repeat: five presses give exactly one pulse
    rises = 0; highs = 0;
    for (int i = 0; i < 5; i++) begin
      key(KT, 0);
      idle(2, 1);
    end
    idle(P + 5, 1);
    check("typematic_pulses", rises, 1);
    check("pulse_len", highs, P);
    idle(H, 1);
    key(KT, 1);
    key(KT, 0);
    check("second_pulse", freeze, 1);
    key(KT, 1);
    key(KC, 1);
    wait_idle();

    // OSD: second edge in holdoff dropped, later edge accepted
    rises = 0;
    step(1, 1, 0, 7'h00, 0, 1);
    idle(20, 1);
    step(1, 1, 0, 7'h00, 0, 1);
    idle(H, 1);
    check("osd_holdoff_pulses", rises, 1);
    wait_idle();
    step(1, 1, 0, 7'h00, 0, 1);
    check("osd_third_edge", freeze, 1);
    check("osd_pulses", rises, 2);
    wait_idle();

    // aron=0 blocks everything
    rises = 0;
    step(1, 0, 1, KC, 0, 0);
    step(1, 0, 1, KT, 0, 0);
    step(1, 0, 0, 7'h00, 0, 1);
    idle(3, 0);
    check("aron_off_freeze", rises, 0);
    check("aron_off_busy", busy, 0);
    step(1, 0, 1, KT, 1, 0);
    step(1, 0, 1, KC, 1, 0);
    // aron drop at pulse cycle 5
    step(1, 1, 0, 7'h00, 0, 1);
    idle(4, 1);
    check("pre_drop_freeze", freeze, 1);
    idle(1, 0);
    check("aron_drop_freeze", freeze, 0);
    check("aron_drop_busy", busy, 1);
    idle(H - 2, 1);
    check("aron_drop_holdoff", busy, 1);
    wait_idle();

    // forwarding of a full Ctrl+trigger press/release sequence
    fwd = 0;
    key(KC, 0);
    key(KT, 0);
    key(KT, 1);
    key(KC, 1);
    check("fwd_count", fwd, SW ? 2 : 4);
    wait_idle();

    // reset mid-pulse clears ctrl_held
    key(KC, 0);
    key(KT, 0);
    idle(3, 1);
    step(0, 1, 0, 7'h00, 0, 0);
    check("rst_freeze", freeze, 0);
    check("rst_busy", busy, 0);
    key(KT, 1);
    key(KT, 0);
    check("no_ctrl_pulse", freeze, 0);
    key(KT, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_a, r_v, r_u, r_o;
      logic [6:0] r_c;
      int sel;
      r_rst = ($urandom_range(0, 499) != 0);
      r_a   = ($urandom_range(0, 19) != 0);
      r_v   = ($urandom_range(0, 3) == 0);
      sel   = $urandom_range(0, 3);
      r_c   = (sel == 0) ? KC : (sel == 1) ? KT : 7'($urandom_range(0, 127));
      r_u   = $urandom_range(0, 1) != 0;
      r_o   = ($urandom_range(0, 39) == 0) ? !osd_freeze : osd_freeze;
      step(r_rst, r_a, r_v, r_c, r_u, r_o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
